reg4_write_arbiter: RTL

- Shares one 4-bit register (register4_sync_reset class: clk, reset, data, q) among NUM_REQ write requesters.
- Round-robin arbitration with a per-requester req/ack handshake, plus a high-priority clear channel that drives the register's sync reset.
- Holds the register data input stable between writes, so a register with no enable keeps its value. Sits between client FSMs and the register.

---
 rtl/reg4_arb_pkg.sv | 23 ++
 rtl/reg4_write_arbiter_rr_pick.sv | 39 +++
 rtl/reg4_write_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/reg4_arb_pkg.sv
// Shared types and helpers for the reg4 write arbiter.
// Optional readback checking is enabled with the REG4_ARB_READBACK_EN macro.
package reg4_arb_pkg;

  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    CLEAR  = 2'd2,
    VERIFY = 2'd3
  } arb_state_e;

  // Width of an index able to address n requesters (never narrower than 1 bit).
  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/reg4_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from ptr+1 with wraparound, so the last winner gets lowest priority.
module rr_pick
  import reg4_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            cand_s;
  logic [IW-1:0] cand_idx_s;

  // Scan all N positions starting after the pointer, keeping the first hit.
  always_comb begin
    gnt        = '0;
    idx        = '0;
    any        = 1'b0;
    cand_s     = 0;
    cand_idx_s = '0;
    for (int off = 1; off <= N; off++) begin
      cand_s     = (int'(ptr) + off) % N;
      cand_idx_s = IW'(cand_s);
      if (!any && req[cand_idx_s]) begin
        any             = 1'b1;
        gnt[cand_idx_s] = 1'b1;
        idx             = cand_idx_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/reg4_write_arbiter.sv
// Shares one 4-bit sync-reset register among NUM_REQ writers with round-robin
// arbitration and a high-priority clear channel. reg_data is held between
// operations so an enable-less register keeps its value.
// Define REG4_ARB_READBACK_EN to add a VERIFY state that checks reg_q after
// each write/clear and reports mismatches on rb_err.
module reg4_write_arbiter
  import reg4_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int IW      = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      clr_req,
  output logic                      clr_ack,
  output logic [DATA_W-1:0]         reg_data,
  output logic                      reg_we,
  output logic                      reg_rst,
  input  logic [DATA_W-1:0]         reg_q,
  output logic                      busy,
  output logic [IW-1:0]             owner
`ifdef REG4_ARB_READBACK_EN
  ,
  output logic                      rb_err
`endif
);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [DATA_W-1:0]   reg_data_q, reg_data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                clr_ack_q, clr_ack_d;
  logic                reg_we_q, reg_we_d;
  logic                reg_rst_q, reg_rst_d;
  logic                busy_q, busy_d;
`ifdef REG4_ARB_READBACK_EN
  logic                rb_err_q, rb_err_d;
  logic                vclr_q, vclr_d;   // VERIFY is checking a clear, not a write
`else
  logic                unused_reg_q_s;
`endif

  logic [NUM_REQ-1:0]  unused_pick_gnt_s;
  logic [IW-1:0]       pick_idx_s;
  logic                pick_any_s;
  logic [DATA_W-1:0]   req_data_arr_s [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_data_arr_s[g] = req_data[g*DATA_W +: DATA_W];
  end

`ifndef REG4_ARB_READBACK_EN
  assign unused_reg_q_s = ^reg_q;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (unused_pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Next-state and registered-output logic; strobes default low every cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    reg_data_d = reg_data_q;
    ack_d      = '0;
    clr_ack_d  = 1'b0;
    reg_we_d   = 1'b0;
    reg_rst_d  = 1'b0;
`ifdef REG4_ARB_READBACK_EN
    rb_err_d   = 1'b0;
    vclr_d     = vclr_q;
`endif
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          reg_data_d = '0;
          reg_rst_d  = 1'b1;
        end else if (pick_any_s) begin
          state_d    = WRITE;
          owner_d    = pick_idx_s;
          ptr_d      = pick_idx_s;
          reg_data_d = req_data_arr_s[pick_idx_s];
          reg_we_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
`ifdef REG4_ARB_READBACK_EN
        state_d = VERIFY;
        vclr_d  = 1'b0;
`else
        state_d        = IDLE;
        ack_d[owner_q] = 1'b1;
`endif
      end
      CLEAR: begin
`ifdef REG4_ARB_READBACK_EN
        state_d = VERIFY;
        vclr_d  = 1'b1;
`else
        state_d   = IDLE;
        clr_ack_d = 1'b1;
`endif
      end
`ifdef REG4_ARB_READBACK_EN
      VERIFY: begin
        state_d  = IDLE;
        rb_err_d = (reg_q != reg_data_q);
        if (vclr_q) begin
          clr_ack_d = 1'b1;
        end else begin
          ack_d[owner_q] = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; asynchronous reset returns to an idle, zeroed
  // interface with requester 0 first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(NUM_REQ - 1);
      owner_q    <= '0;
      reg_data_q <= '0;
      ack_q      <= '0;
      clr_ack_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef REG4_ARB_READBACK_EN
      rb_err_q   <= 1'b0;
      vclr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      reg_data_q <= reg_data_d;
      ack_q      <= ack_d;
      clr_ack_q  <= clr_ack_d;
      reg_we_q   <= reg_we_d;
      reg_rst_q  <= reg_rst_d;
      busy_q     <= busy_d;
`ifdef REG4_ARB_READBACK_EN
      rb_err_q   <= rb_err_d;
      vclr_q     <= vclr_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign clr_ack  = clr_ack_q;
  assign reg_data = reg_data_q;
  assign reg_we   = reg_we_q;
  assign reg_rst  = reg_rst_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
`ifdef REG4_ARB_READBACK_EN
  assign rb_err   = rb_err_q;
`endif

endmodule
